// File: rtl/dac_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_pkg : shared constants for the DAC stream driver
// Rev 1.0
// ----------------------------------------------------------------------------
package dac_pkg;

  localparam logic UR_HOLD = 1'b0;
  localparam logic UR_MID  = 1'b1;

  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_sample_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_sample_fifo : synchronous FIFO with a registered head-of-queue output
// Rev 1.0
// ----------------------------------------------------------------------------
module dac_sample_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] ram_rd_q;
  logic              do_push;
  logic              do_pop;

  assign o_full  = (level_q == LVL_W'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
    // A write landing on the next head address is not visible through the RAM read port yet.
    byp_d = do_push && (wr_ptr_q == rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      byp_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      byp_q    <= byp_d;
    end
  end

  always_ff @(posedge clk) begin
    byp_data_q <= i_data;
  end

  generate
    if (DEPTH >= 64) begin : g_bram
      (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
        ram_rd_q <= mem_q[rd_ptr_d];
      end
    end else begin : g_regs
      (* ram_style = "logic" *) logic [DATA_W-1:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
        ram_rd_q <= mem_q[rd_ptr_d];
      end
    end
  endgenerate

  assign o_head = byp_q ? byp_data_q : ram_rd_q;

endmodule
`default_nettype wire

// File: rtl/dac_stream_out.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dac_stream_out : paces FIFO-buffered samples onto a parallel DAC with latch clock
// Rev 1.0
// ----------------------------------------------------------------------------
module dac_stream_out
  import dac_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int CHANNELS = 1,
  parameter  int DEPTH    = 16,
  parameter  int DIV_W    = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_enable,
  input  logic [DIV_W-1:0]  in_period,
  input  logic              in_signed,
  input  logic              in_underrun_mode,
  input  logic              in_clear_underrun,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_ready,
  output logic [DATA_W-1:0] out_dac_data,
  output logic              out_dac_clk,
  output logic [CH_W-1:0]   out_dac_chan,
  output logic              out_underrun,
  output logic [LVL_W-1:0]  out_level
);

  localparam logic [DATA_W-1:0] MID     = DATA_W'(midscale(DATA_W));
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CHANNELS - 1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  period_q, period_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dac_clk_q, dac_clk_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [CH_W-1:0]   next_chan_q, next_chan_d;
  logic              underrun_q, underrun_d;
  logic              live_q;
  logic              underrun_set;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] stored;
  logic              push;
  logic              pop;
  logic              tick;
  logic [DIV_W:0]    half_p;

  assign out_ready = live_q && !fifo_full;
  assign push      = in_valid && out_ready;
  assign stored    = in_signed ? (in_data ^ MID) : in_data;
  assign tick      = (cnt_q == '0) && in_enable;
  assign pop       = tick && !fifo_empty;
  // ceil(P/2) with P = period_q + 1
  assign half_p    = ({1'b0, period_q} + (DIV_W + 1)'(2)) >> 1;

  dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (push),
    .i_data  (stored),
    .i_pop   (pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (out_level)
  );

  always_comb begin
    cnt_d        = cnt_q;
    period_d     = period_q;
    data_d       = data_q;
    dac_clk_d    = 1'b0;
    chan_d       = chan_q;
    next_chan_d  = next_chan_q;
    underrun_set = 1'b0;
    if (!in_enable) begin
      cnt_d       = '0;
      chan_d      = '0;
      next_chan_d = '0;
    end else begin
      // Judged on the pre-edge count so the latch edge trails the data change by a cycle.
      dac_clk_d = ({1'b0, cnt_q} >= half_p);
      if (tick) begin
        period_d    = (in_period == '0) ? DIV_W'(1) : in_period;
        cnt_d       = DIV_W'(1);
        chan_d      = next_chan_q;
        next_chan_d = (next_chan_q == LAST_CH) ? '0 : next_chan_q + 1'b1;
        if (!fifo_empty) begin
          data_d = fifo_head;
        end else begin
          underrun_set = 1'b1;
          if (in_underrun_mode == UR_MID) data_d = MID;
        end
      end else if (cnt_q == period_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    underrun_d = underrun_set | (underrun_q & ~in_clear_underrun);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      period_q    <= DIV_W'(1);
      data_q      <= MID;
      dac_clk_q   <= 1'b0;
      chan_q      <= '0;
      next_chan_q <= '0;
      underrun_q  <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      data_q      <= data_d;
      dac_clk_q   <= dac_clk_d;
      chan_q      <= chan_d;
      next_chan_q <= next_chan_d;
      underrun_q  <= underrun_d;
      live_q      <= 1'b1;
    end
  end

  assign out_dac_data = data_q;
  assign out_dac_clk  = dac_clk_q;
  assign out_dac_chan = chan_q;
  assign out_underrun = underrun_q;

endmodule
`default_nettype wire

// File: doc/dac_stream_out.md
# dac_stream_out

Parametrised streaming driver for parallel-input video/audio DACs such as the board's 8-bit DAC port. Accepts samples over a valid/ready stream into an internal FIFO, paces them out at a programmable sample period, and generates the DAC latch clock. Supports time-multiplexed multi-channel DACs, signed or offset-binary input, and defined underrun behaviour. It sits between the design's sample generator in `main` and the top-level DAC pins.

## Interface
Parameters:
- `DATA_W`, 8: sample width in bits.
- `CHANNELS`, 1: time-multiplexed DAC channels, 1..8; `CH_W = max(1, clog2(CHANNELS))`.
- `DEPTH`, 16: FIFO depth in samples, power of two, minimum 2.
- `DIV_W`, 16: width of the period register.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `in_enable` in 1: run output pacing.
- `in_period` in DIV_W: clocks per DAC word minus 1; 0 is treated as 1.
- `in_signed` in 1: 1 means input is two's complement and is converted to offset binary by inverting the MSB.
- `in_underrun_mode` in 1: 0 holds the last word, 1 outputs midscale.
- `in_clear_underrun` in 1: clears the sticky underrun flag.
- `in_valid` in 1, `in_data` in DATA_W, `out_ready` out 1: sample input stream.
- `out_dac_data` out DATA_W: registered DAC word.
- `out_dac_clk` out 1: DAC latch clock; the DAC latches on the rising edge.
- `out_dac_chan` out CH_W: channel index of the current word.
- `out_underrun` out 1: sticky underrun flag.
- `out_level` out clog2(DEPTH+1): FIFO occupancy.

## Operation
- **Reset values:** `out_dac_data` = midscale (`1<<(DATA_W-1)`), `out_dac_clk`=0, `out_dac_chan`=0, `out_underrun`=0, `out_level`=0, `out_ready`=0 during reset and 1 after. The FIFO is emptied, the counter is 0, and the period latch is 1.
- **Push:** a sample is pushed when `in_valid && out_ready`. `out_ready = !full`.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - `in_data` and `in_signed` are sampled at push time; the conversion happens before storage.
- **Pacing counter:** `cnt` runs 0..P-1, where P = latched period + 1.
  - A tick occurs when `cnt==0 && in_enable`.
  - The period is latched from `in_period` only at a tick (clamped to ≥1). Mid-run changes therefore take effect at the next word boundary.
- **At a tick:**
  - If the FIFO is non-empty: pop the head into `out_dac_data`.
  - If the FIFO is empty: set `out_underrun`, and load either the last word (mode 0) or midscale (mode 1).
  - In both cases, advance `out_dac_chan` modulo CHANNELS; it wraps CHANNELS-1 to 0. The first word after enable/reset carries chan 0.
  - An underrun still advances the channel. Frame alignment is the producer's responsibility.
- **out_dac_clk:** 0 while `cnt < ceil(P/2)`, 1 otherwise. The rising edge is therefore ≥1 clock after data changes and data is held ≥1 clock after it.
- **in_enable low:** `cnt` is held at 0, `out_dac_clk`=0, `out_dac_chan` returns to 0, and `out_dac_data` holds its value. The FIFO keeps accepting pushes.
- **Enable deasserted mid-word:** the word is abandoned. The clock drops on the next edge.
- **Underrun flag:** `in_clear_underrun` clears `out_underrun`. If a clear and a new underrun occur in the same cycle, set wins.
- **Level:** `out_level` is updated every cycle. A simultaneous push and pop leaves it unchanged.

## Timing
- **Push-to-output latency:** a push accepted at edge t is visible in the FIFO at t+1. It can be popped by a tick at t+1 and appears on `out_dac_data` after edge t+2. There is no bypass, so a push into an empty FIFO coinciding with a tick is an underrun.
- **Output rate:** one word per P clocks. The maximum is clock/2 (P=2: one cycle low, one cycle high).
- All outputs are registered. There are no combinational paths from inputs to outputs, except that `out_ready` derives from registered full.

## Structure
- **Package `dac_pkg`:** the underrun mode constants (`UR_HOLD`=0, `UR_MID`=1) and a `midscale(DATA_W)` constant function.
- **Sub-module `dac_sample_fifo`:** synchronous FIFO with parameters DATA_W and DEPTH.
  - Registered read, full/empty/level outputs.
  - Maps to iCE40 BRAM when DEPTH ≥ 64; otherwise uses registers.
- The top-level pacing, conversion and channel logic stay in `dac_stream_out`.

## Test plan
- **Basic pacing:** reset, then DATA_W=8, P=4, push 0x10,0x20,0x30 with enable high.
  - Required: `out_dac_data` steps 0x10→0x20→0x30 every 4 clocks, and `out_dac_clk` shows 2 low and 2 high per word.
  - Required: `out_underrun` rises at the 4th tick and the word holds at 0x30.
- **Signed conversion:** `in_signed`=1, push 0x80, 0x00, 0x7F.
  - Required: outputs 0x00, 0x80, 0xFF.
  - Required: with `in_underrun_mode`=1 and the FIFO empty, the next word is 0x80.
- **Multi-channel:** CHANNELS=3, P=2, push 6 samples.
  - Required: `out_dac_chan` sequence 0,1,2,0,1,2, each paired with its sample in order.
  - Required: dropping enable mid-frame returns chan to 0 and forces `out_dac_clk` low.
- **Full FIFO:** DEPTH=4, enable low, push 6 samples with valid held.
  - Required: exactly 4 are accepted, `out_ready`=0, `out_level`=4.
  - Required: after enable, the pops re-raise `out_ready`.
- **Period change mid-word:** run with P=8 and change `in_period` to 2 at cnt=3.
  - Required: the current word completes 8 clocks, then the following words last 3 clocks.
- **Reset mid-operation:** assert reset with a half-full FIFO and dac_clk high.
  - Required: the next cycle shows every output at its reset value and `out_level`=0.
  - Required: a clear and an underrun in the same cycle leave the flag set.
